// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 640x480 VGA raster timing generator.
// Optional build macro VGA_PIXDIV_EN: pix_en divides clk by two (50 MHz -> 25 MHz pixels).
module vga_timing_gen #(
    parameter int HTOTAL  = 800,
    parameter int HSYNC   = 96,
    parameter int HLEFT   = 144,
    parameter int HPIXELS = 640,
    parameter int VTOTAL  = 521,
    parameter int VSYNC   = 2,
    parameter int VTOP    = 31,
    parameter int VPIXELS = 480
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       bright,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_en,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST  = 10'(HTOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(VTOTAL - 1);
    localparam logic [9:0] H_SYNC  = 10'(HSYNC);
    localparam logic [9:0] V_SYNC  = 10'(VSYNC);
    localparam logic [9:0] H_FIRST = 10'(HLEFT + 1);
    localparam logic [9:0] H_END   = 10'(HLEFT + HPIXELS);
    localparam logic [9:0] V_FIRST = 10'(VTOP + 1);
    localparam logic [9:0] V_END   = 10'(VTOP + VPIXELS);

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_vis;
    logic       v_vis;

    // Next raster position; counters move only on a pixel strobe.
    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_next = hcount;
        v_next = vcount;
        if (pix_en) begin
            h_next = h_wrap ? 10'd0 : hcount + 10'd1;
            if (h_wrap) begin
                v_next = v_wrap ? 10'd0 : vcount + 10'd1;
            end
        end
        h_vis = (h_next >= H_FIRST) && (h_next <= H_END);
        v_vis = (v_next >= V_FIRST) && (v_next <= V_END);
    end

    // Pixel strobe: toggles for a divided clock, else held high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_en <= 1'b0;
        end else begin
`ifdef VGA_PIXDIV_EN
            pix_en <= ~pix_en;
`else
            pix_en <= 1'b1;
`endif
        end
    end

    // Counters plus decode of the next position, so outputs align with counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= 10'd0;
            vcount      <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            bright      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                hsync  <= !(h_next < H_SYNC);
                vsync  <= !(v_next < V_SYNC);
                bright <= h_vis && v_vis;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized checks of vga_timing_gen against a
// position-from-edge-count model; a small-geometry instance covers frame wraps.
module tb_vga_timing_gen;

`ifdef VGA_PIXDIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // full-size geometry
    localparam int BHT = 800, BHS = 96, BHL = 144, BHP = 640;
    localparam int BVT = 521, BVS = 2, BVTP = 31, BVP = 480;
    // reduced geometry for fast frame wraps
    localparam int SHT = 40, SHS = 6, SHL = 8, SHP = 20;
    localparam int SVT = 20, SVS = 2, SVTP = 3, SVP = 10;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    logic rst_s = 1'b1;

    logic [9:0] hcount_b, vcount_b, hcount_s, vcount_s;
    logic bright_b, hsync_b, vsync_b, pix_en_b, fs_b;
    logic bright_s, hsync_s, vsync_s, pix_en_s, fs_s;

    longint k_b = 0;
    longint k_s = 0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_big (
        .clk(clk), .rst(rst_b),
        .hcount(hcount_b), .vcount(vcount_b),
        .bright(bright_b), .hsync(hsync_b), .vsync(vsync_b),
        .pix_en(pix_en_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .HTOTAL(SHT), .HSYNC(SHS), .HLEFT(SHL), .HPIXELS(SHP),
        .VTOTAL(SVT), .VSYNC(SVS), .VTOP(SVTP), .VPIXELS(SVP)
    ) u_small (
        .clk(clk), .rst(rst_s),
        .hcount(hcount_s), .vcount(vcount_s),
        .bright(bright_s), .hsync(hsync_s), .vsync(vsync_s),
        .pix_en(pix_en_s), .frame_start(fs_s)
    );

    wire [24:0] got_b = {hcount_b, vcount_b, bright_b, hsync_b, vsync_b, pix_en_b, fs_b};
    wire [24:0] got_s = {hcount_s, vcount_s, bright_s, hsync_s, vsync_s, pix_en_s, fs_s};

    // edges since reset release: the whole model state
    always @(posedge clk) begin
        k_b <= rst_b ? 64'sd0 : k_b + 1;
        k_s <= rst_s ? 64'sd0 : k_s + 1;
    end

    // expected {h, v, bright, hsync, vsync, pix_en, frame_start} after k edges
    function automatic logic [24:0] model(longint k, int ht, int hs, int hl, int hp,
                                          int vt, int vs, int vtp, int vp);
        longint n;
        bit pe, adv, br, fs;
        int h, v;
`ifdef VGA_PIXDIV_EN
        pe  = (k % 2) == 1;
        n   = k / 2;
        adv = (k > 0) && ((k % 2) == 0);
`else
        pe  = k >= 1;
        n   = (k >= 1) ? k - 1 : 0;
        adv = k >= 2;
`endif
        if (n == 0) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, pe, 1'b0};
        h  = int'(n % ht);
        v  = int'((n / ht) % vt);
        br = (h >= hl + 1) && (h <= hl + hp) && (v >= vtp + 1) && (v <= vtp + vp);
        fs = adv && ((n % (ht * vt)) == 0);
        return {10'(h), 10'(v), br, !(h < hs), !(v < vs), pe, fs};
    endfunction

    function automatic logic [24:0] exp_b();
        return model(k_b, BHT, BHS, BHL, BHP, BVT, BVS, BVTP, BVP);
    endfunction

    function automatic logic [24:0] exp_s();
        return model(k_s, SHT, SHS, SHL, SHP, SVT, SVS, SVTP, SVP);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [24:0] rv;
        rv = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rst_b = 1'b1; rst_s = 1'b1;
        tick(); tick();
        rst_b = 1'b0; rst_s = 1'b0;
        repeat ($urandom_range(100, 2000)) tick();
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (got_b !== rv) begin
                fails++;
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got_b, rv);
            end
        end
    endtask

    task automatic test_line_timing();
        int hlow, last_pulse, wraps, w0, w1;
        logic [9:0] prev_h;
        hlow = 0; last_pulse = -1; wraps = 0; w0 = 0; w1 = 0;
        prev_h = hcount_b;
        rst_b = 1'b0;
        for (int c = 1; c <= 2 * BHT * DIV + 20; c++) begin
            tick();
            tests++;
            if (got_b !== exp_b()) begin
                fails++;
                $display("FAIL line_timing k=%0d got=%h exp=%h", k_b, got_b, exp_b());
            end
            if (!hsync_b) hlow++;
            else if (hlow > 0) begin
                last_pulse = hlow;
                hlow = 0;
            end
            if (hcount_b == 10'd0 && prev_h == 10'(BHT - 1)) begin
                if (wraps == 0) w0 = c;
                else w1 = c;
                wraps++;
            end
            prev_h = hcount_b;
        end
        tests++;
        if (last_pulse != BHS * DIV) begin
            fails++;
            $display("FAIL hsync_width got=%0d exp=%0d", last_pulse, BHS * DIV);
        end
        tests++;
        if (wraps != 2 || (w1 - w0) != BHT * DIV) begin
            fails++;
            $display("FAIL line_period got=%0d exp=%0d (wraps=%0d)", w1 - w0, BHT * DIV, wraps);
        end
    endtask

    task automatic test_active_window();
        int br31, br32, budget;
        br31 = 0; br32 = 0; budget = 0;
        while (!(vcount_b == 10'd33 && hcount_b == 10'd0) && budget < 40 * BHT * DIV) begin
            tick();
            budget++;
            tests++;
            if (got_b !== exp_b()) begin
                fails++;
                $display("FAIL active_window k=%0d got=%h exp=%h", k_b, got_b, exp_b());
            end
            if (bright_b && vcount_b == 10'd31) br31++;
            if (bright_b && vcount_b == 10'd32) br32++;
        end
        tests++;
        if (budget >= 40 * BHT * DIV) begin
            fails++;
            $display("FAIL active_window_timeout got=%0d exp=<%0d", budget, 40 * BHT * DIV);
        end
        tests++;
        if (br31 != 0) begin
            fails++;
            $display("FAIL bright_line31 got=%0d exp=0", br31);
        end
        tests++;
        if (br32 != BHP * DIV) begin
            fails++;
            $display("FAIL bright_line32 got=%0d exp=%0d", br32, BHP * DIV);
        end
    endtask

    task automatic test_frame_wrap();
        int pulses, p0, p1;
        pulses = 0; p0 = 0; p1 = 0;
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        for (int c = 1; c <= 2 * SHT * SVT * DIV + 30; c++) begin
            tick();
            tests++;
            if (got_s !== exp_s()) begin
                fails++;
                $display("FAIL frame_wrap k=%0d got=%h exp=%h", k_s, got_s, exp_s());
            end
            if (fs_s) begin
                if (pulses == 0) p0 = c;
                else p1 = c;
                pulses++;
            end
        end
        tests++;
        if (pulses != 2 || (p1 - p0) != SHT * SVT * DIV) begin
            fails++;
            $display("FAIL frame_period got=%0d exp=%0d (pulses=%0d)", p1 - p0, SHT * SVT * DIV, pulses);
        end
    endtask

    task automatic test_mid_frame_reset();
        int budget;
        logic [24:0] rv;
        rv = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        budget = 0;
        while (!(hcount_s == 10'd18 && vcount_s == 10'd9) && budget < 2 * SHT * SVT * DIV) begin
            tick();
            budget++;
        end
        tests++;
        if (!bright_s || budget >= 2 * SHT * SVT * DIV) begin
            fails++;
            $display("FAIL mid_frame_setup got=bright%0b exp=bright1 (budget=%0d)", bright_s, budget);
        end
        rst_s = 1'b1;
        tick();
        tests++;
        if (got_s !== rv) begin
            fails++;
            $display("FAIL mid_frame_reset got=%h exp=%h", got_s, rv);
        end
        rst_s = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if (got_s !== exp_s() || fs_s !== 1'b0) begin
                fails++;
                $display("FAIL mid_frame_release k=%0d got=%h exp=%h", k_s, got_s, exp_s());
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(1, 2 * SHT * SVT * DIV)) begin
                tick();
                tests++;
                if (got_s !== exp_s()) begin
                    fails++;
                    $display("FAIL random run%0d k=%0d got=%h exp=%h", it, k_s, got_s, exp_s());
                end
            end
            rst_s = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                tick();
                tests++;
                if (got_s !== exp_s()) begin
                    fails++;
                    $display("FAIL random rst%0d got=%h exp=%h", it, got_s, exp_s());
                end
            end
            rst_s = 1'b0;
        end
    endtask

    initial begin
        if (BHT > 1024 || BVT > 1024 || SHT > 1024 || SVT > 1024) begin
            $display("FAIL param_limits HTOTAL/VTOTAL exceed 1024");
            $fatal(1);
        end
        test_reset();
        test_line_timing();
        test_active_window();
        test_frame_wrap();
        test_mid_frame_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running 640x480 VGA raster timing generator.
- Produces hcount, vcount, bright, hsync and vsync. The tile-lookup stage consumes hcount, vcount and bright; the sync signals drive the board connector.
- Sits directly upstream of the tile-select/tile-map logic. Its visible window is defined to match that stage's address arithmetic: column = (hcount-145)>>4, row = (vcount-32)>>4.

Parameters:
- HTOTAL, 800, pixels per line (counter wraps at HTOTAL-1).
- HSYNC, 96, hsync pulse width in pixels.
- HLEFT, 144, last non-visible column before the active area.
- HPIXELS, 640, active columns.
- VTOTAL, 521, lines per frame.
- VSYNC, 2, vsync pulse width in lines.
- VTOP, 31, last non-visible line before the active area.
- VPIXELS, 480, active lines.

Ports:
- clk  input  1  system clock (50 MHz board clock when VGA_PIXDIV_EN is defined).
- rst  input  1  synchronous active-high reset.
- hcount  output  10  horizontal pixel counter.
- vcount  output  10  vertical line counter.
- bright  output  1  high inside the active video window.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- pix_en  output  1  pixel-advance strobe.
- frame_start  output  1  one-clk pulse when the raster returns to (0,0).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk only.
- Reset values: hcount=0, vcount=0, hsync=1, vsync=1, bright=0, frame_start=0, pix_en=0.
- Advance rule: counters move only on a clk edge where pix_en=1.
  - hcount increments and wraps HTOTAL-1 -> 0.
  - On that wrap, vcount increments and wraps VTOTAL-1 -> 0.
  - vcount never changes without an hcount wrap.
- Decode: hsync, vsync and bright are registered and decoded from the next-state counter values, so they are cycle-aligned with the hcount/vcount they describe.
  - hsync=0 iff hcount < HSYNC (0..95).
  - vsync=0 iff vcount < VSYNC (0..1).
  - bright=1 iff HLEFT+1 <= hcount <= HLEFT+HPIXELS (145..784) AND VTOP+1 <= vcount <= VTOP+VPIXELS (32..511).
  - Window width is exactly 640x480; boundaries are inclusive as stated.
- Right after reset, counters read (0,0) with hsync/vsync=1. This is intentional: the outputs hold their reset values until the first advance, after which decode is normal.
- frame_start: asserted for exactly one clk, on the cycle where the counters first hold (0,0) after a wrap from (HTOTAL-1, VTOTAL-1).
  - Not asserted on reset release.
  - Low when pix_en=0 cycles follow.
- Latency: counters and decoded outputs change together on the same edge; no extra pipeline stage.
- Reset mid-frame: on the next edge all outputs return to reset values regardless of position. No partial pulse continues.
- Widths: internal compares are 10-bit unsigned. Required parameter limits are HTOTAL <= 1024 and VTOTAL <= 1024. Bench asserts these at elaboration.

Optional Feature:
VGA_PIXDIV_EN:
- Defined: pix_en is a divide-by-2 toggle register (reset 0, inverts every clk). Counters advance every second clk, giving a 25 MHz pixel rate from 50 MHz.
  - First advance occurs on the 2nd clk edge after rst deasserts.
  - One line = 1600 clk.
- Undefined: pix_en is held at 1 (still 0 during reset). Counters advance every clk after reset.
  - One line = 800 clk.
  - Intended for simulation speed or an externally supplied 25 MHz clk.

Test Plan:
- Reset check: hold rst 3 cycles at arbitrary counter position -> hcount=0, vcount=0, hsync=1, vsync=1, bright=0, frame_start=0, pix_en=0.
- Line timing (macro defined): release reset and count -> hsync low for hcount 0..95, i.e. 192 clk per pulse. hcount wraps 799 -> 0 every 1600 clk; vcount increments by 1 at each wrap.
- Active window: vcount=32 -> bright rises with hcount=145 and falls when hcount becomes 785. With vcount=31 or 512, bright stays 0 for the whole line.
- Frame wrap: run to (799,520) -> next advance gives (0,0), vsync=0, and frame_start high for exactly 1 clk. vsync returns to 1 at vcount=2. Frame period = 800*521 pixels.
- Mid-frame reset: assert rst at (400,250) with bright=1 -> next edge bright=0 and counters (0,0). No frame_start pulse on release.
- Macro undefined: hcount increments every clk after reset. Line period = 800 clk; frame_start period = 416800 clk.
